scene_packet_decoder: RTL
=========================

Name: scene_packet_decoder

Overview:
- Sits directly downstream of the SPI byte-to-64-bit accumulator and upstream of the raytracing controller's scene storage.
- Consumes a stream of 64-bit words, each marked by a one-cycle valid pulse.
- Parses the stream into framed packets (header plus payload) and writes sphere records into scene memory.
- Latches the camera word, issues a frame-commit pulse, and drives a ready level that the MCU reads as its interrupt/flow-control line.

Parameters:
- MAX_SPHERES, 16: capacity of scene memory in 64-bit sphere records.
- ADDR_W, 4: scene memory address width; must satisfy 2**ADDR_W >= MAX_SPHERES.
- TIMEOUT_CYCLES, 1000000: maximum clk cycles allowed between payload words before the packet is aborted (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock (100 MHz domain, same as accumulator).
- rst_  in  1  reset; one clock; reset is asynchronous and active-low.
- i_dv  in  1  one-cycle pulse; i_word valid. Pulses may occur on adjacent cycles.
- i_word  in  64  accumulated word from the SPI accumulator.
- o_mem_we  out  1  scene memory write strobe, one cycle per payload word.
- o_mem_addr  out  ADDR_W  scene memory write address.
- o_mem_wdata  out  64  scene memory write data.
- o_sphere_count  out  ADDR_W+1  number of valid spheres from the last completed WRITE_SPHERES packet.
- o_camera  out  64  last accepted camera word.
- o_commit  out  1  one-cycle pulse requesting the controller to render with the current scene.
- o_ready  out  1  high when idle and accepting a new header; drives the MCU interrupt pin.
- o_err_count  out  8  saturating count of rejected headers and timeouts.

Behaviour:
- Header word fields:
  - [63:56] magic, must be 8'hA5.
  - [55:48] opcode.
  - [47:40] payload count N.
  - [39:0] ignored.
- Opcodes:
  - 8'h01 WRITE_SPHERES: requires 1 <= N <= MAX_SPHERES.
  - 8'h02 SET_CAMERA: requires N == 1.
  - 8'h03 COMMIT: requires N == 0.
- States: IDLE, PAYLOAD, CAMERA.
- IDLE, on i_dv:
  - Valid WRITE_SPHERES header: go to PAYLOAD, idx <= 0, len <= N.
  - Valid SET_CAMERA header: go to CAMERA.
  - Valid COMMIT header: o_commit = 1 on the next cycle only; remain in IDLE.
  - Anything else (bad magic, unknown opcode, illegal N): stay in IDLE, increment o_err_count, no other effect.
- PAYLOAD, on i_dv:
  - Next cycle: o_mem_we = 1, o_mem_addr = idx, o_mem_wdata = i_word; idx increments.
  - On the word where idx == len-1: o_sphere_count <= len and return to IDLE. The count update is visible in the same cycle as the final o_mem_we.
  - Payload words are never interpreted as headers.
- CAMERA, on i_dv: o_camera <= i_word (visible next cycle), then return to IDLE.
- Latency: every output effect appears exactly one cycle after the sampled i_dv. Back-to-back i_dv pulses are each consumed; no word is dropped.
- Timeout:
  - A counter runs in PAYLOAD and CAMERA and clears on each i_dv.
  - When it reaches TIMEOUT_CYCLES-1 with no i_dv: return to IDLE, increment o_err_count, leave o_sphere_count and o_camera unchanged.
  - Memory entries already written by the aborted packet are not rolled back.
  - The counter is idle (held at 0) in IDLE.
- o_ready:
  - Registered; equals (next state == IDLE).
  - Falls the cycle after a valid WRITE_SPHERES or SET_CAMERA header.
  - Rises the cycle after the final payload word or a timeout.
  - Stays high through COMMIT and rejected headers.
- o_err_count saturates at 8'hFF and never wraps.
- Reset values while rst_ is low:
  - State IDLE.
  - o_ready 0; goes to 1 on the first clk edge after rst_ rises.
  - o_mem_we 0, o_mem_addr 0, o_mem_wdata 0.
  - o_sphere_count 0, o_camera 0, o_commit 0, o_err_count 0.
  - idx and timeout counter 0.
- Reset mid-packet discards the packet; the next word after reset is parsed as a header.

Test Plan:
- Reset then header 64'hA501_0300_0000_0000 followed by three payload words (one-cycle gaps) -> three o_mem_we pulses at addr 0,1,2 with matching data; o_sphere_count = 3 after the third; o_ready low between header+1 and last+1.
- Header 64'hA502_0100_... then 64'h1234_5678_9ABC_DEF0 on adjacent cycles -> o_camera = 64'h1234_5678_9ABC_DEF0 one cycle after the second pulse; o_ready back high.
- Header 64'hA503_0000_... -> o_commit high for exactly one cycle, one cycle after i_dv; o_ready stays 1; no memory write.
- Each of 64'h5A01_0100_..., 64'hA509_0000_..., and 64'hA501_1100_... (N=17 > 16) -> o_err_count increments 1,2,3; state stays IDLE; no writes; o_ready stays 1.
- WRITE_SPHERES with N=2, one payload word, then silence (TIMEOUT_CYCLES overridden to 100) -> return to IDLE after 100 cycles; o_err_count +1; o_sphere_count keeps its prior value; next header is accepted.
- rst_ pulsed low mid-PAYLOAD after 1 of 4 words -> all outputs at reset values; o_ready 1 one clk after release; subsequent COMMIT header produces o_commit.

Source files
------------

// File: rtl/scene_packet_decoder.sv
// Scene packet decoder: parses framed 64-bit words from the SPI accumulator into
// sphere-memory writes, a latched camera word, commit pulses and a ready level.
module scene_packet_decoder #(
  parameter int MAX_SPHERES    = 16,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              i_dv,
  input  logic [63:0]       i_word,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [63:0]       o_mem_wdata,
  output logic [ADDR_W:0]   o_sphere_count,
  output logic [63:0]       o_camera,
  output logic              o_commit,
  output logic              o_ready,
  output logic [7:0]        o_err_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0] MAX_N = 9'(MAX_SPHERES);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CAMERA} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   len;
  logic [CNT_W-1:0]  tmo_cnt;

  logic       magic_ok;
  logic [7:0] opcode;
  logic [7:0] n_words;
  logic       hdr_spheres;
  logic       hdr_camera;
  logic       hdr_commit;

  assign magic_ok    = (i_word[63:56] == 8'hA5);
  assign opcode      = i_word[55:48];
  assign n_words     = i_word[47:40];
  assign hdr_spheres = magic_ok && (opcode == 8'h01) && (n_words != 8'd0)
                       && ({1'b0, n_words} <= MAX_N);
  assign hdr_camera  = magic_ok && (opcode == 8'h02) && (n_words == 8'd1);
  assign hdr_commit  = magic_ok && (opcode == 8'h03) && (n_words == 8'd0);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state          <= S_IDLE;
      idx            <= '0;
      len            <= '0;
      tmo_cnt        <= '0;
      o_mem_we       <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_wdata    <= '0;
      o_sphere_count <= '0;
      o_camera       <= '0;
      o_commit       <= 1'b0;
      o_ready        <= 1'b0;
      o_err_count    <= '0;
    end else begin
      o_mem_we <= 1'b0;
      o_commit <= 1'b0;
      case (state)
        S_IDLE: begin
          o_ready <= 1'b1;
          tmo_cnt <= '0;
          if (i_dv) begin
            if (hdr_spheres) begin
              state   <= S_PAYLOAD;
              idx     <= '0;
              len     <= n_words[ADDR_W:0];
              o_ready <= 1'b0;
            end else if (hdr_camera) begin
              state   <= S_CAMERA;
              o_ready <= 1'b0;
            end else if (hdr_commit) begin
              o_commit <= 1'b1;
            end else if (o_err_count != 8'hFF) begin
              o_err_count <= o_err_count + 8'd1;
            end
          end
        end
        S_PAYLOAD: begin
          if (i_dv) begin
            o_mem_we    <= 1'b1;
            o_mem_addr  <= idx;
            o_mem_wdata <= i_word;
            idx         <= idx + 1'b1;
            tmo_cnt     <= '0;
            // Count becomes visible together with the final write strobe.
            if ({1'b0, idx} == len - 1'b1) begin
              o_sphere_count <= len;
              state          <= S_IDLE;
              o_ready        <= 1'b1;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= S_IDLE;
            o_ready <= 1'b1;
            tmo_cnt <= '0;
            if (o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_CAMERA: begin
          if (i_dv) begin
            o_camera <= i_word;
            state    <= S_IDLE;
            o_ready  <= 1'b1;
            tmo_cnt  <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= S_IDLE;
            o_ready <= 1'b1;
            tmo_cnt <= '0;
            if (o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
